// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and FSM encoding for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam logic        ResetEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic        AckEnable    = 1'b1;
  localparam logic        AckDisable   = 1'b0;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [3:0]  BusSelAll    = 4'b1111;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StGrantD = 2'b01,
    StGrantI = 2'b10,
    StDone   = 2'b11
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Pipeline-side request/response ports and Wishbone-style bus signals of the arbiter.
interface mem_bus_arbiter_if;

  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_sel;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        flush;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_adr_o;
  logic [31:0] bus_dat_o;
  logic [31:0] bus_dat_i;
  logic        bus_ack_i;
  logic        bus_timeout_o;
  logic        stallreq_if;
  logic        stallreq_mem;

  // Arbiter side.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_sel, d_addr, d_wdata, flush, bus_dat_i, bus_ack_i,
    output i_rdata, i_ack, d_rdata, d_ack, bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o,
           bus_adr_o, bus_dat_o, bus_timeout_o, stallreq_if, stallreq_mem
  );

  // Pipeline plus memory slave side.
  modport master (
    output i_req, i_addr, d_req, d_we, d_sel, d_addr, d_wdata, flush, bus_dat_i, bus_ack_i,
    input  i_rdata, i_ack, d_rdata, d_ack, bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o,
           bus_adr_o, bus_dat_o, bus_timeout_o, stallreq_if, stallreq_mem
  );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one memory bus between instruction fetch and the MEM-stage data port.
// Data wins by default; a streak counter forces a waiting fetch through after a bounded run.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.slave mbus
);

  localparam int unsigned   StreakW   = $clog2(MAX_DATA_STREAK + 1);
  localparam int unsigned   TmoW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_DATA_STREAK);
  localparam logic [TmoW-1:0]    TmoLast   = TmoW'(TIMEOUT_CYCLES - 1);

  arb_state_e         state_q;
  logic [StreakW-1:0] streak_q;
  logic [TmoW-1:0]    tmo_q;
  logic               drop_q;

  logic i_ok;
  logic i_due;
  logic drop_now;
  logic tmo_hit;
  logic bus_end;

  assign i_ok     = mbus.i_req && !mbus.flush;
  assign i_due    = i_ok && (streak_q == StreakMax);
  // A flush in the finishing cycle must also suppress the fetch ack.
  assign drop_now = drop_q || mbus.flush;
  assign tmo_hit  = (tmo_q == TmoLast);
  assign bus_end  = mbus.bus_ack_i || tmo_hit;

  assign mbus.stallreq_if  = mbus.i_req && !mbus.i_ack;
  assign mbus.stallreq_mem = mbus.d_req && !mbus.d_ack;

  always_ff @(posedge clk) begin
    if (rst == ResetEnable) begin
      state_q            <= StIdle;
      streak_q           <= '0;
      tmo_q              <= '0;
      drop_q             <= 1'b0;
      mbus.bus_cyc_o     <= 1'b0;
      mbus.bus_stb_o     <= 1'b0;
      mbus.bus_we_o      <= WriteDisable;
      mbus.bus_sel_o     <= 4'b0000;
      mbus.bus_adr_o     <= ZeroWord;
      mbus.bus_dat_o     <= ZeroWord;
      mbus.i_rdata       <= ZeroWord;
      mbus.d_rdata       <= ZeroWord;
      mbus.i_ack         <= AckDisable;
      mbus.d_ack         <= AckDisable;
      mbus.bus_timeout_o <= 1'b0;
    end else begin
      mbus.i_ack         <= AckDisable;
      mbus.d_ack         <= AckDisable;
      mbus.bus_timeout_o <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mbus.d_req && !i_due) begin
            state_q        <= StGrantD;
            tmo_q          <= '0;
            mbus.bus_cyc_o <= 1'b1;
            mbus.bus_stb_o <= 1'b1;
            mbus.bus_we_o  <= mbus.d_we;
            mbus.bus_sel_o <= mbus.d_sel;
            mbus.bus_adr_o <= mbus.d_addr;
            mbus.bus_dat_o <= mbus.d_wdata;
            if (streak_q != StreakMax) begin
              streak_q <= streak_q + StreakW'(1);
            end
          end else if (i_ok) begin
            state_q        <= StGrantI;
            tmo_q          <= '0;
            streak_q       <= '0;
            mbus.bus_cyc_o <= 1'b1;
            mbus.bus_stb_o <= 1'b1;
            mbus.bus_we_o  <= WriteDisable;
            mbus.bus_sel_o <= BusSelAll;
            mbus.bus_adr_o <= mbus.i_addr;
            mbus.bus_dat_o <= ZeroWord;
          end
        end
        StGrantD: begin
          if (bus_end) begin
            // Ack wins over a coinciding timeout expiry.
            state_q            <= StDone;
            mbus.bus_cyc_o     <= 1'b0;
            mbus.bus_stb_o     <= 1'b0;
            mbus.d_rdata       <= mbus.bus_ack_i ? mbus.bus_dat_i : ZeroWord;
            mbus.d_ack         <= AckEnable;
            mbus.bus_timeout_o <= !mbus.bus_ack_i;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        StGrantI: begin
          if (mbus.flush) begin
            drop_q <= 1'b1;
          end
          if (bus_end) begin
            state_q            <= StDone;
            mbus.bus_cyc_o     <= 1'b0;
            mbus.bus_stb_o     <= 1'b0;
            mbus.i_rdata       <= mbus.bus_ack_i ? mbus.bus_dat_i : ZeroWord;
            mbus.i_ack         <= drop_now ? AckDisable : AckEnable;
            mbus.bus_timeout_o <= !mbus.bus_ack_i;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          drop_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: requester and slave models plus grant/ack monitors.
module tb_mem_bus_arbiter;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } grant_t;

  typedef struct packed {
    logic        is_d;
    logic        tmo;
    logic [31:0] rdata;
  } ack_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   slv_delay;
  int   wait_cnt;
  logic cyc_prev;

  grant_t      dq[$];
  logic [31:0] iq[$];
  grant_t      exp_grant_q[$];
  ack_t        exp_ack_q[$];

  mem_bus_arbiter_if m ();

  mem_bus_arbiter #(
    .MAX_DATA_STREAK(4),
    .TIMEOUT_CYCLES (255)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mbus(m)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_rdata(input logic [31:0] adr);
    if (adr == 32'h0000_0100) return 32'hDEAD_BEEF;
    return adr ^ 32'hA5A5_0000;
  endfunction

  // Memory slave: acks after slv_delay wait cycles; negative delay never acks.
  always @(posedge clk) begin
    #1;
    m.bus_ack_i = 1'b0;
    m.bus_dat_i = $urandom;
    if (m.bus_cyc_o && m.bus_stb_o) begin
      if (slv_delay >= 0 && wait_cnt == slv_delay) begin
        m.bus_ack_i = 1'b1;
        m.bus_dat_i = model_rdata(m.bus_adr_o);
        wait_cnt    = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Data requester: holds each request until d_ack, then presents the next one.
  always @(posedge clk) begin
    grant_t r;
    #1;
    if (m.d_ack || !m.d_req) begin
      if (dq.size() != 0) begin
        r         = dq.pop_front();
        m.d_we    = r.we;
        m.d_sel   = r.sel;
        m.d_addr  = r.adr;
        m.d_wdata = r.dat;
        m.d_req   = 1'b1;
      end else begin
        m.d_req = 1'b0;
      end
    end
  end

  // Fetch requester: a flush discards the outstanding fetch.
  always @(posedge clk) begin
    #1;
    if (m.flush) begin
      m.i_req = 1'b0;
    end else if (m.i_ack || !m.i_req) begin
      if (iq.size() != 0) begin
        m.i_addr = iq.pop_front();
        m.i_req  = 1'b1;
      end else begin
        m.i_req = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    grant_t g;
    ack_t   a;
    if (m.bus_cyc_o === 1'b1 && cyc_prev !== 1'b1) begin
      check_eq("gnt_pending", 32'(exp_grant_q.size() != 0), 32'd1);
      if (exp_grant_q.size() != 0) begin
        g = exp_grant_q.pop_front();
        check_eq("gnt_stb", 32'(m.bus_stb_o), 32'd1);
        check_eq("gnt_we", 32'(m.bus_we_o), 32'(g.we));
        check_eq("gnt_sel", 32'(m.bus_sel_o), 32'(g.sel));
        check_eq("gnt_adr", m.bus_adr_o, g.adr);
        if (g.we) check_eq("gnt_dat", m.bus_dat_o, g.dat);
      end
    end
    cyc_prev = m.bus_cyc_o;
    if (m.i_ack === 1'b1 || m.d_ack === 1'b1) begin
      check_eq("ack_excl", 32'(m.i_ack & m.d_ack), 32'd0);
      check_eq("ack_pending", 32'(exp_ack_q.size() != 0), 32'd1);
      if (exp_ack_q.size() != 0) begin
        a = exp_ack_q.pop_front();
        check_eq("ack_port", 32'(m.d_ack), 32'(a.is_d));
        check_eq("ack_rdata", m.d_ack ? m.d_rdata : m.i_rdata, a.rdata);
        check_eq("ack_tmo", 32'(m.bus_timeout_o), 32'(a.tmo));
      end
    end else if (!rst) begin
      check_eq("tmo_no_ack", 32'(m.bus_timeout_o), 32'd0);
    end
  end

  // ack_kind: 0 none, 1 data returned, 2 timeout.
  task automatic exp_d(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                       input logic [31:0] wd, input int ack_kind);
    grant_t g;
    ack_t   a;
    g = '{we: we, sel: sel, adr: adr, dat: wd};
    exp_grant_q.push_back(g);
    if (ack_kind != 0) begin
      a = '{is_d: 1'b1, tmo: (ack_kind == 2), rdata: (ack_kind == 2) ? 32'h0 : model_rdata(adr)};
      exp_ack_q.push_back(a);
    end
  endtask

  task automatic exp_i(input logic [31:0] adr, input int ack_kind);
    grant_t g;
    ack_t   a;
    g = '{we: 1'b0, sel: 4'b1111, adr: adr, dat: 32'h0};
    exp_grant_q.push_back(g);
    if (ack_kind != 0) begin
      a = '{is_d: 1'b0, tmo: (ack_kind == 2), rdata: (ack_kind == 2) ? 32'h0 : model_rdata(adr)};
      exp_ack_q.push_back(a);
    end
  endtask

  task automatic req_d(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                       input logic [31:0] wd);
    grant_t r;
    r = '{we: we, sel: sel, adr: adr, dat: wd};
    dq.push_back(r);
  endtask

  task automatic drain(input string tag, input int limit);
    int k;
    k = 0;
    while ((exp_grant_q.size() != 0 || exp_ack_q.size() != 0 || m.bus_cyc_o) && k < limit) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, 32'(exp_grant_q.size() + exp_ack_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    #2;
  endtask

  task automatic wait_cyc(input string tag, input int limit);
    int k;
    k = 0;
    while (m.bus_cyc_o !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, 32'(m.bus_cyc_o), 32'd1);
  endtask

  initial begin
    int n;
    int cyc_cnt;
    logic seen;
    n_checks  = 0;
    n_errors  = 0;
    slv_delay = 0;
    wait_cnt  = 0;
    cyc_prev  = 1'b0;
    rst       = 1'b1;
    m.i_req = 1'b0; m.i_addr = '0; m.d_req = 1'b0; m.d_we = 1'b0; m.d_sel = '0;
    m.d_addr = '0; m.d_wdata = '0; m.flush = 1'b0; m.bus_dat_i = '0; m.bus_ack_i = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_cyc_stb", 32'({m.bus_cyc_o, m.bus_stb_o, m.bus_we_o}), 32'd0);
    check_eq("rst_sel", 32'(m.bus_sel_o), 32'd0);
    check_eq("rst_adr", m.bus_adr_o, 32'd0);
    check_eq("rst_dat", m.bus_dat_o, 32'd0);
    check_eq("rst_acks", 32'({m.i_ack, m.d_ack, m.bus_timeout_o}), 32'd0);
    check_eq("rst_rdata", m.i_rdata | m.d_rdata, 32'd0);
    check_eq("rst_stall", 32'({m.stallreq_if, m.stallreq_mem}), 32'd0);
    #2 rst = 1'b0;

    // Single load, slave acks one cycle after stb.
    slv_delay = 1;
    exp_d(1'b0, 4'b1111, 32'h100, 32'h0, 1);
    req_d(1'b0, 4'b1111, 32'h100, 32'h0);
    n = 0;
    seen = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (k == 1) check_eq("stall_mem_hi", 32'(m.stallreq_mem), 32'd1);
      if (m.d_ack) begin
        seen = 1'b1;
        n = k;
        check_eq("stall_mem_lo", 32'(m.stallreq_mem), 32'd0);
      end
    end
    check_eq("load_latency", 32'(n), 32'd4);
    drain("drain_load", 20);

    // Simultaneous fetch and store: data first.
    slv_delay = 0;
    exp_d(1'b1, 4'b0011, 32'h200, 32'h1234, 1);
    exp_i(32'h400, 1);
    req_d(1'b1, 4'b0011, 32'h200, 32'h1234);
    iq.push_back(32'h400);
    drain("drain_simul", 40);

    // Continuous contention: four data grants per fetch grant.
    for (int k = 0; k < 10; k++) req_d(1'b0, 4'b1111, 32'h1000 + 32'(4 * k), 32'h0);
    for (int k = 0; k < 3; k++) iq.push_back(32'h2000 + 32'(4 * k));
    for (int k = 0; k < 4; k++) exp_d(1'b0, 4'b1111, 32'h1000 + 32'(4 * k), 32'h0, 1);
    exp_i(32'h2000, 1);
    for (int k = 4; k < 8; k++) exp_d(1'b0, 4'b1111, 32'h1000 + 32'(4 * k), 32'h0, 1);
    exp_i(32'h2004, 1);
    for (int k = 8; k < 10; k++) exp_d(1'b0, 4'b1111, 32'h1000 + 32'(4 * k), 32'h0, 1);
    exp_i(32'h2008, 1);
    drain("drain_streak", 200);

    // Flush during a fetch: bus completes, no i_ack; next fetch is normal.
    slv_delay = 3;
    exp_i(32'h800, 0);
    iq.push_back(32'h800);
    wait_cyc("flush_grant", 20);
    #2 m.flush = 1'b1;
    @(negedge clk);
    #2 m.flush = 1'b0;
    drain("drain_flush", 30);
    exp_i(32'h900, 1);
    iq.push_back(32'h900);
    drain("drain_refetch", 30);

    // Slave never acks: forced termination after 255 cycles.
    slv_delay = -1;
    exp_d(1'b0, 4'b1111, 32'h300, 32'h0, 2);
    req_d(1'b0, 4'b1111, 32'h300, 32'h0);
    cyc_cnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (m.bus_cyc_o) cyc_cnt++;
      if (m.d_ack) seen = 1'b1;
    end
    check_eq("tmo_seen", 32'(seen), 32'd1);
    check_eq("tmo_cyc_len", 32'(cyc_cnt), 32'd255);
    drain("drain_tmo", 20);

    // Reset during a data grant; the held request is re-granted afterwards.
    exp_d(1'b0, 4'b1111, 32'h500, 32'h0, 0);
    exp_d(1'b0, 4'b1111, 32'h500, 32'h0, 1);
    req_d(1'b0, 4'b1111, 32'h500, 32'h0);
    wait_cyc("rst_grant", 20);
    #2 rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_cyc_stb", 32'({m.bus_cyc_o, m.bus_stb_o}), 32'd0);
    check_eq("midrst_ack", 32'(m.d_ack), 32'd0);
    check_eq("midrst_adr", m.bus_adr_o, 32'd0);
    #2 rst = 1'b0;
    slv_delay = 2;
    drain("drain_rst", 30);

    check_eq("dq_empty", 32'(dq.size() + iq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
